delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line.sv | 91 +++++++++
 tb/tb_delay_line.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// -----------------------------------------------------------------------------
// delay_line
//
// Fixed-depth sample delay line with an intermediate tap and a fill counter.
// Each enabled clock shifts a new sample into stage 1 and moves every held
// sample one stage further. The last stage is the full-depth delayed output.
// A fill counter tracks how many genuine samples the line holds, so that
// downstream logic can ignore dout until the line has primed.
//
// Ports
//   clk       in   1      single clock, all state updates on the rising edge
//   rst       in   1      synchronous active-high reset, highest priority
//   en        in   1      sample strobe, advances the line by one stage
//   flush     in   1      synchronous clear of stages and fill count
//   din       in   WIDTH  sample written into stage 1
//   tap_sel   in   SEL_W  tap select, value k selects stage k+1
//   dout      out  WIDTH  contents of stage DEPTH
//   tap_out   out  WIDTH  contents of the selected stage, zero if out of range
//   fill_cnt  out  CNT_W  number of valid samples held, saturates at DEPTH
//   full      out  1      fill_cnt == DEPTH, dout carries a genuine sample
// -----------------------------------------------------------------------------
module delay_line #(
    parameter int WIDTH = 17,              // sample width, 1..32
    parameter int DEPTH = 4,               // number of stages, 2..32
    localparam int SEL_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] tap_out,
    output logic [CNT_W-1:0] fill_cnt,
    output logic             full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // stage[k] holds stage k+1 of the line: stage[0] is the newest sample,
    // stage[DEPTH-1] the oldest.
    logic [WIDTH-1:0] stage [DEPTH];

    // -------------------------------------------------------------------------
    // Shift register and fill counter
    // -------------------------------------------------------------------------
    // rst and flush clear exactly the same state, so they share one branch;
    // both outrank en, which means a sample presented alongside either is lost.
    // NOTE: every stage is cleared on reset, not just the counter, because
    // dout and tap_out must be known zeros right after reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            fill_cnt <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage read its
            // neighbour's old value, giving a true shift regardless of order.
            stage[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
            if (fill_cnt != FULL_CNT) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign dout = stage[DEPTH-1];
    assign full = (fill_cnt == FULL_CNT);

    // Tap mux. Select codes at or above DEPTH (only reachable when DEPTH is
    // not a power of two) match no stage and fall through to zero.
    // NOTE: tap_out is given its default before the loop so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tap_out = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == SEL_W'(k)) begin
                tap_out = stage[k];
            end
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// -----------------------------------------------------------------------------
// tb_delay_line
//
// Drives two delay lines (DEPTH=4 and DEPTH=3, both WIDTH=17) from shared
// inputs. The reference model is a history of accepted samples since the
// last clear: stage k holds the k-th most recent sample, or zero if fewer
// than k samples have been accepted.
// -----------------------------------------------------------------------------
module tb_delay_line;

    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] din = '0;
    logic [1:0]   tap_sel = '0;

    logic [W-1:0] d4_dout, d4_tap;
    logic [2:0]   d4_fill;
    logic         d4_full;
    logic [W-1:0] d3_dout, d3_tap;
    logic [1:0]   d3_fill;
    logic         d3_full;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] hist [$];

    always #5 clk = ~clk;

    delay_line #(.WIDTH(W), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din),
        .tap_sel(tap_sel), .dout(d4_dout), .tap_out(d4_tap),
        .fill_cnt(d4_fill), .full(d4_full)
    );

    delay_line #(.WIDTH(W), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din),
        .tap_sel(tap_sel), .dout(d3_dout), .tap_out(d3_tap),
        .fill_cnt(d3_fill), .full(d3_full)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] exp_stage(input int depth, input int k);
        if (k < 1 || k > depth) return '0;
        if (hist.size() < k) return '0;
        return hist[hist.size() - k];
    endfunction

    function automatic int exp_fill(input int depth);
        return (hist.size() < depth) ? hist.size() : depth;
    endfunction

    // One clock edge: drive inputs on the falling edge, update the model at
    // the rising edge, return 1 time unit later for sampling.
    task automatic step(input logic r, input logic f, input logic e, input logic [W-1:0] d);
        @(negedge clk);
        rst = r; flush = f; en = e; din = d;
        @(posedge clk);
        if (r || f) hist.delete();
        else if (e) hist.push_back(d);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, '0);
        checks++;
        if (d4_dout !== '0 || d4_fill !== 3'd0 || d4_full !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%h fill=%0d full=%b required 0/0/0", d4_dout, d4_fill, d4_full);
        end
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t); #1;
            checks++;
            if (d4_tap !== '0 || d3_tap !== '0) begin
                errors++;
                $display("FAIL reset_tap%0d: tap4=%h tap3=%h required 0", t, d4_tap, d3_tap);
            end
        end
    endtask

    task automatic test_fill;
        logic [W-1:0] want_dout [5] = '{17'd0, 17'd0, 17'd0, 17'd1, 17'd2};
        int           want_fill [5] = '{1, 2, 3, 4, 4};
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, W'(i + 1));
            checks++;
            if (d4_dout !== want_dout[i] || d4_dout !== exp_stage(4, 4) ||
                int'(d4_fill) != want_fill[i] || d4_full !== (i >= 3)) begin
                errors++;
                $display("FAIL fill_edge%0d: dout=%h fill=%0d full=%b required %h/%0d/%b",
                         i + 1, d4_dout, d4_fill, d4_full, want_dout[i], want_fill[i], i >= 3);
            end
        end
    endtask

    task automatic test_stall;
        int enabled = 0;
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b1, W'(i));
            enabled++;
            if (i == 2) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0, W'(17'h0AAAA + g));
                    for (int t = 0; t < 4; t++) begin
                        tap_sel = 2'(t); #1;
                        checks++;
                        if (d4_tap !== exp_stage(4, t + 1) || d4_fill !== 3'd2 || d4_dout !== '0) begin
                            errors++;
                            $display("FAIL stall_gap%0d_tap%0d: tap=%h fill=%0d dout=%h required %h/2/0",
                                     g, t, d4_tap, d4_fill, d4_dout, exp_stage(4, t + 1));
                        end
                    end
                end
            end
            checks++;
            if (d4_dout !== ((enabled == 4) ? 17'd1 : exp_stage(4, 4))) begin
                errors++;
                $display("FAIL stall_dout_en%0d: dout=%h required %h", enabled, d4_dout, exp_stage(4, 4));
            end
        end
    endtask

    task automatic test_taps;
        logic [W-1:0] want4 [4] = '{17'd40, 17'd30, 17'd20, 17'd10};
        logic [W-1:0] want3 [4] = '{17'd40, 17'd30, 17'd20, 17'd0};
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, W'(i * 10));
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t); #1;
            checks++;
            if (d4_tap !== want4[t] || d3_tap !== want3[t]) begin
                errors++;
                $display("FAIL taps_sel%0d: tap4=%h tap3=%h required %h/%h", t, d4_tap, d3_tap, want4[t], want3[t]);
            end
        end
    endtask

    task automatic test_flush;
        // line is full from test_taps
        step(1'b0, 1'b1, 1'b1, 17'h1FFFF);
        checks++;
        if (d4_fill !== 3'd0 || d4_full !== 1'b0 || d4_dout !== '0 || d3_fill !== 2'd0) begin
            errors++;
            $display("FAIL flush: fill=%0d full=%b dout=%h fill3=%0d required 0/0/0/0", d4_fill, d4_full, d4_dout, d3_fill);
        end
        for (int t = 0; t < 4; t++) begin
            tap_sel = 2'(t); #1;
            checks++;
            if (d4_tap !== '0) begin
                errors++;
                $display("FAIL flush_tap%0d: tap=%h required 0", t, d4_tap);
            end
        end
        step(1'b0, 1'b0, 1'b1, 17'h00123);
        checks++;
        if (d4_fill !== 3'd1 || d4_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_refill: fill=%0d full=%b required 1/0", d4_fill, d4_full);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 17'h00011);
        step(1'b0, 1'b0, 1'b1, 17'h00022);
        step(1'b1, 1'b0, 1'b1, 17'h00033);
        checks++;
        if (d4_dout !== '0 || d4_fill !== 3'd0 || d4_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: dout=%h fill=%0d full=%b required 0/0/0", d4_dout, d4_fill, d4_full);
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, W'(i));
            checks++;
            if (d4_full !== (i == 4) || int'(d4_fill) != i) begin
                errors++;
                $display("FAIL reset_mid_refill%0d: fill=%0d full=%b required %0d/%b", i, d4_fill, d4_full, i, i == 4);
            end
        end
    endtask

    task automatic test_width;
        logic [W-1:0] pat [2] = '{17'h10000, 17'h1FFFF};
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, pat[0]);
        step(1'b0, 1'b0, 1'b1, pat[1]);
        step(1'b0, 1'b0, 1'b1, 17'h0);
        step(1'b0, 1'b0, 1'b1, 17'h0);
        checks++;
        if (d4_dout !== pat[0]) begin
            errors++;
            $display("FAIL width_10000: dout=%h required %h", d4_dout, pat[0]);
        end
        step(1'b0, 1'b0, 1'b1, 17'h0);
        checks++;
        if (d4_dout !== pat[1]) begin
            errors++;
            $display("FAIL width_1ffff: dout=%h required %h", d4_dout, pat[1]);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            logic r, f, e;
            r = ($urandom_range(99) < 2);
            f = ($urandom_range(99) < 5);
            e = ($urandom_range(99) < 70);
            step(r, f, e, W'($urandom));
            tap_sel = 2'($urandom_range(3)); #1;
            checks++;
            if (d4_dout !== exp_stage(4, 4) || d4_tap !== exp_stage(4, int'(tap_sel) + 1) ||
                int'(d4_fill) != exp_fill(4) || d4_full !== (exp_fill(4) == 4) ||
                d3_dout !== exp_stage(3, 3) || d3_tap !== exp_stage(3, int'(tap_sel) + 1) ||
                int'(d3_fill) != exp_fill(3) || d3_full !== (exp_fill(3) == 3)) begin
                errors++;
                $display("FAIL random_cyc%0d: d4 dout=%h tap=%h fill=%0d full=%b required %h/%h/%0d/%b; d3 dout=%h tap=%h fill=%0d full=%b required %h/%h/%0d/%b",
                         c, d4_dout, d4_tap, d4_fill, d4_full,
                         exp_stage(4, 4), exp_stage(4, int'(tap_sel) + 1), exp_fill(4), exp_fill(4) == 4,
                         d3_dout, d3_tap, d3_fill, d3_full,
                         exp_stage(3, 3), exp_stage(3, int'(tap_sel) + 1), exp_fill(3), exp_fill(3) == 3);
            end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_stall;
        test_taps;
        test_flush;
        test_reset_mid;
        test_width;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
